// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: fetch, datapath-control and data-memory signals of the sequencer; retired port exists only with SEQ_PERF_CNT_EN
interface multicycle_sequencer_if;
  logic        instr_valid;
  logic [31:0] instr_code;
  logic        instr_ready;
  logic        zero;
  logic        mem_ack;
  logic        pc_en;
  logic        pc_branch;
  logic [1:0]  sign;
  logic        alu_src;
  logic [3:0]  alu_con;
  logic        choose_reg;
  logic        reg_write;
  logic        mem_req;
  logic        mem_we;
  logic        halted;
  logic        illegal;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired;
`endif
  modport master (
`ifdef SEQ_PERF_CNT_EN
    output retired,
`endif
    input  instr_valid, instr_code, zero, mem_ack,
    output instr_ready, pc_en, pc_branch, sign, alu_src, alu_con, choose_reg,
    output reg_write, mem_req, mem_we, halted, illegal
  );
  modport slave (
`ifdef SEQ_PERF_CNT_EN
    input  retired,
`endif
    output instr_valid, instr_code, zero, mem_ack,
    input  instr_ready, pc_en, pc_branch, sign, alu_src, alu_con, choose_reg,
    input  reg_write, mem_req, mem_we, halted, illegal
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: fetch/decode/exec/mem/wb control FSM for a shared datapath; SEQ_PERF_CNT_EN adds a retired-instruction counter
module multicycle_sequencer #(
  parameter int OPW = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input logic clk,
  input logic reset,
  multicycle_sequencer_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_HALT = OPW'(6'b111111);
  localparam logic [OPW-1:0] F_ADD   = OPW'(6'b100000);
  localparam logic [OPW-1:0] F_SUB   = OPW'(6'b100010);
  localparam logic [OPW-1:0] F_AND   = OPW'(6'b100100);
  localparam logic [OPW-1:0] F_OR    = OPW'(6'b100101);
  localparam logic [OPW-1:0] F_SLT   = OPW'(6'b101010);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, nstate;
  logic [OPW-1:0] op, op_n, fn, fn_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ill_q, ill_n, hlt_q, hlt_n, rdy_q;
  logic [1:0] sign_q;
  logic [3:0] con_q;
  logic src_q, rd_q, rw_q, mreq_q, mwe_q;
  logic is_r, is_beq, is_sw, is_mem, legal, act;
  logic [1:0] ctl_sign;
  logic [3:0] alu_fn, ctl_con;
  assign is_r   = op == OP_R;
  assign is_beq = op == OP_BEQ;
  assign is_sw  = op == OP_SW;
  assign is_mem = is_sw || op == OP_LW;
  assign legal  = is_r ? fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT}
                       : op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ};
  assign alu_fn = fn == F_SUB ? 4'b0110 : fn == F_AND ? 4'b0000 : fn == F_OR ? 4'b0001 :
                  fn == F_SLT ? 4'b0111 : 4'b0010;
  assign ctl_con = is_r ? alu_fn : op == OP_ANDI ? 4'b0000 : op == OP_ORI ? 4'b0001 :
                   is_beq ? 4'b0110 : 4'b0010;
  assign ctl_sign = is_r ? 2'b10 : (op == OP_ANDI || op == OP_ORI) ? 2'b01 : 2'b00;
  // datapath controls are live from EXEC through WB so MEM and WB see EXEC's settings
  assign act = nstate inside {EXEC, MEM, WB};
  // next state, IR capture, memory wait counter and sticky flags
  always_comb begin
    nstate = state;
    op_n = op;
    fn_n = fn;
    cnt_n = '0;
    ill_n = ill_q;
    hlt_n = hlt_q;
    unique case (state)
      FETCH: if (rdy_q && bus.instr_valid) begin
        op_n = bus.instr_code[31 -: OPW];
        fn_n = bus.instr_code[OPW-1:0];
        nstate = DECODE;
      end
      DECODE: begin
        nstate = op == OP_HALT ? HALT : legal ? EXEC : FETCH;
        hlt_n = hlt_q || op == OP_HALT;
        ill_n = ill_q || (op != OP_HALT && !legal);
      end
      EXEC: nstate = is_beq ? FETCH : is_mem ? MEM : WB;
      MEM: if (bus.mem_ack) nstate = is_sw ? FETCH : WB;
      else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
        nstate = FETCH;
        ill_n = 1'b1;
      end else cnt_n = cnt + 1'b1;
      WB: nstate = FETCH;
      HALT: nstate = HALT;
      default: nstate = FETCH;
    endcase
  end
  // state, IR and registered control outputs derived from the next state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      op <= '0;
      fn <= '0;
      cnt <= '0;
      ill_q <= 1'b0;
      hlt_q <= 1'b0;
      rdy_q <= 1'b0;
      sign_q <= '0;
      con_q <= '0;
      src_q <= 1'b0;
      rd_q <= 1'b0;
      rw_q <= 1'b0;
      mreq_q <= 1'b0;
      mwe_q <= 1'b0;
    end else begin
      state <= nstate;
      op <= op_n;
      fn <= fn_n;
      cnt <= cnt_n;
      ill_q <= ill_n;
      hlt_q <= hlt_n;
      rdy_q <= nstate == FETCH;
      sign_q <= act ? ctl_sign : 2'b00;
      con_q <= act ? ctl_con : 4'b0000;
      src_q <= act && !(is_r || is_beq);
      rd_q <= act && is_r;
      rw_q <= nstate == WB;
      mreq_q <= nstate == MEM;
      mwe_q <= nstate == MEM && is_sw;
    end
  assign bus.instr_ready = rdy_q;
  assign bus.pc_en = rdy_q && bus.instr_valid;
  assign bus.pc_branch = state == EXEC && is_beq && bus.zero;
  assign bus.sign = sign_q;
  assign bus.alu_src = src_q;
  assign bus.alu_con = con_q;
  assign bus.choose_reg = rd_q;
  assign bus.reg_write = rw_q;
  assign bus.mem_req = mreq_q;
  assign bus.mem_we = mwe_q;
  assign bus.halted = hlt_q;
  assign bus.illegal = ill_q;
`ifdef SEQ_PERF_CNT_EN
  logic done;
  logic [31:0] retired_q;
  assign done = state == WB || (state == EXEC && is_beq) || (state == MEM && bus.mem_ack && is_sw);
  // count completed instructions; wraps naturally at 32 bits
  always_ff @(posedge clk or negedge reset)
    if (!reset) retired_q <= '0;
    else retired_q <= retired_q + 32'(done);
  assign bus.retired = retired_q;
`endif
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: scoreboard bench; stimulus queues expected per-instruction traces, a monitor rebuilds and compares them
module tb_multicycle_sequencer;
  typedef struct {
    int lat, rw, br, mreq, mwe;
    logic [3:0] con;
    logic src, rd;
    logic [1:0] sign;
    logic ill;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0, errors = 0, ack_delay = 0, nrec = 0;
  rec_t sb[$];
  logic any_out;
  always #5 clk = ~clk;
  multicycle_sequencer_if bus();
  multicycle_sequencer #(.OPW(6), .MEM_TIMEOUT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign any_out = |{bus.pc_en, bus.pc_branch, bus.sign, bus.alu_src, bus.alu_con, bus.choose_reg,
                     bus.reg_write, bus.mem_req, bus.mem_we, bus.halted, bus.illegal};
  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  function automatic rec_t mk(int lat, int rw, int br, int mreq, int mwe, logic [3:0] con,
                              logic src, logic rd, logic [1:0] sign, logic ill);
    rec_t r;
    r.lat = lat; r.rw = rw; r.br = br; r.mreq = mreq; r.mwe = mwe;
    r.con = con; r.src = src; r.rd = rd; r.sign = sign; r.ill = ill;
    return r;
  endfunction
  task automatic wait_ready();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.instr_ready && n < 100);
    if (!bus.instr_ready) chk("wait_instr_ready", 0, 1);
  endtask
  task automatic issue(logic [31:0] code, logic z, int dly, rec_t e, bit push);
    wait_ready();
    bus.zero = z;
    ack_delay = dly;
    bus.instr_code = code;
    bus.instr_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask
  // data memory model: acks during the ack_delay-th cycle of a request, never when ack_delay is 0
  initial begin
    int w = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        w++;
        bus.mem_ack = ack_delay != 0 && w == ack_delay;
      end else begin
        w = 0;
        bus.mem_ack = 1'b0;
      end
    end
  end
  // monitor: traces each instruction from its fetch handshake to the next instr_ready (or halt)
  initial begin
    rec_t a, e;
    int t = 0;
    bit open = 0;
    forever begin
      @(negedge clk);
      if (!reset) open = 0;
      else begin
        if (open) begin
          t++;
          a.rw += int'(bus.reg_write); a.br += int'(bus.pc_branch);
          a.mreq += int'(bus.mem_req); a.mwe += int'(bus.mem_we);
          if (t == 2) begin
            a.con = bus.alu_con; a.src = bus.alu_src; a.rd = bus.choose_reg; a.sign = bus.sign;
          end
          if (bus.instr_ready || bus.halted || t >= 60) begin
            open = 0;
            a.lat = t;
            a.ill = bus.illegal;
            nrec++;
            if (sb.size() == 0) chk($sformatf("i%0d_unexpected", nrec), 1, 0);
            else begin
              e = sb.pop_front();
              chk($sformatf("i%0d_latency", nrec), a.lat, e.lat);
              chk($sformatf("i%0d_reg_write_cycles", nrec), a.rw, e.rw);
              chk($sformatf("i%0d_pc_branch_cycles", nrec), a.br, e.br);
              chk($sformatf("i%0d_mem_req_cycles", nrec), a.mreq, e.mreq);
              chk($sformatf("i%0d_mem_we_cycles", nrec), a.mwe, e.mwe);
              chk($sformatf("i%0d_alu_con", nrec), int'(a.con), int'(e.con));
              chk($sformatf("i%0d_alu_src", nrec), int'(a.src), int'(e.src));
              chk($sformatf("i%0d_choose_reg", nrec), int'(a.rd), int'(e.rd));
              chk($sformatf("i%0d_sign", nrec), int'(a.sign), int'(e.sign));
              chk($sformatf("i%0d_illegal", nrec), int'(a.ill), int'(e.ill));
            end
          end
        end
        if (!open && bus.pc_en) begin
          open = 1;
          t = 0;
          a = mk(0, 0, 0, 0, 0, 4'b0, 1'b0, 1'b0, 2'b0, 1'b0);
        end
      end
    end
  end
  initial begin
    int n;
    bus.instr_valid = 1'b0;
    bus.instr_code = '0;
    bus.zero = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("reset_instr_ready", int'(bus.instr_ready), 0);
    chk("reset_outputs", int'(any_out), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("release_instr_ready", int'(bus.instr_ready), 1);
    issue(32'h00432020, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0010, 1'b0, 1'b1, 2'b10, 1'b0), 1);
    issue(32'h10000003, 1'b1, 0, mk(3, 0, 1, 0, 0, 4'b0110, 1'b0, 1'b0, 2'b00, 1'b0), 1);
    issue(32'hAC000004, 1'b0, 3, mk(6, 0, 0, 3, 3, 4'b0010, 1'b1, 1'b0, 2'b00, 1'b0), 1);
`ifdef SEQ_PERF_CNT_EN
    wait_ready();
    chk("retired_after_3", int'(bus.retired), 3);
`endif
    issue(32'h34A5FFFF, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 2'b01, 1'b0), 1);
    issue(32'h10000003, 1'b0, 0, mk(3, 0, 0, 0, 0, 4'b0110, 1'b0, 1'b0, 2'b00, 1'b0), 1);
    issue(32'h8C000004, 1'b0, 3, mk(7, 1, 0, 3, 0, 4'b0010, 1'b1, 1'b0, 2'b00, 1'b0), 1);
    issue(32'h00432022, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0110, 1'b0, 1'b1, 2'b10, 1'b0), 1);
    issue(32'h00432024, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0000, 1'b0, 1'b1, 2'b10, 1'b0), 1);
    issue(32'h00432025, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0001, 1'b0, 1'b1, 2'b10, 1'b0), 1);
    issue(32'h0043202A, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0111, 1'b0, 1'b1, 2'b10, 1'b0), 1);
    issue(32'h3000000F, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0000, 1'b1, 1'b0, 2'b01, 1'b0), 1);
    issue(32'h20000005, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0010, 1'b1, 1'b0, 2'b00, 1'b0), 1);
    issue(32'h8C000004, 1'b0, 0, mk(18, 0, 0, 15, 0, 4'b0010, 1'b1, 1'b0, 2'b00, 1'b1), 1);
    issue(32'hFC000000, 1'b0, 0, mk(2, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1), 1);
    n = 0;
    repeat (20) begin @(posedge clk); #1; n += int'(bus.instr_ready); end
    chk("halt_ready_cycles", n, 0);
    chk("halt_halted", int'(bus.halted), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("unhalt_halted", int'(bus.halted), 0);
    chk("unhalt_illegal", int'(bus.illegal), 0);
    issue(32'hF8000000, 1'b0, 0, mk(2, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1), 1);
    issue(32'h00432020, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0010, 1'b0, 1'b1, 2'b10, 1'b1), 1);
    issue(32'h00000021, 1'b0, 0, mk(2, 0, 0, 0, 0, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b1), 1);
    issue(32'h00432020, 1'b0, 0, mk(0, 0, 0, 0, 0, 4'b0, 1'b0, 1'b0, 2'b0, 1'b0), 0);
    n = 0;
    while (!bus.reg_write && n < 20) begin @(posedge clk); #1; n++; end
    chk("wb_reached", int'(bus.reg_write), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", int'(any_out), 0);
    chk("async_reset_ready", int'(bus.instr_ready), 0);
    @(posedge clk); #1;
    chk("held_reset_outputs", int'(any_out), 0);
    reset = 1'b1;
    issue(32'h34A5FFFF, 1'b0, 0, mk(4, 1, 0, 0, 0, 4'b0001, 1'b1, 1'b0, 2'b01, 1'b0), 1);
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    @(posedge clk); #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the shared fetch unit, register file, ALU and data memory port of the processor datapath.
- Each instruction takes up to five states: fetch, decode, execute, memory, writeback.
- It latches the opcode and funct fields, then drives the datapath's Sign/ALU_src/ALU_con/Reg_write/Choose_reg-style controls one phase at a time.
- It handshakes with the instruction source and the data memory, so the datapath can sit behind variable-latency memories.

Parameters:
- OPW, 6, opcode/funct field width.
- MEM_TIMEOUT, 15, max cycles waiting for mem_ack before the access is aborted.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- instr_valid  input  1  fetch unit presents a valid instruction.
- instr_code  input  32  instruction word, sampled when instr_valid && instr_ready.
- instr_ready  output  1  sequencer accepts the instruction (FETCH state only).
- zero  input  1  ALU zero flag.
- mem_ack  input  1  data memory completed the access.
- pc_en  output  1  advance PC by 4 (one-cycle pulse).
- pc_branch  output  1  load branch target (one-cycle pulse).
- sign  output  2  immediate mode: 00 sign-extend, 01 zero-extend, 10 none.
- alu_src  output  1  0 = register operand, 1 = immediate.
- alu_con  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- choose_reg  output  1  destination select: 1 = rd [15:11], 0 = rt [20:16].
- reg_write  output  1  register file write enable (WB state only).
- mem_req  output  1  data memory request, held until ack or timeout.
- mem_we  output  1  1 = store, valid while mem_req is high.
- halted  output  1  sticky; set by the HALT opcode.
- illegal  output  1  sticky; set on an unknown opcode or funct.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=FETCH; IR fields and timeout counter cleared.
  - All outputs 0, except instr_ready=1 once reset is released.
  - Reset asserted mid-instruction aborts it immediately; no partial write completes.
- Opcode/funct decode:
  - R-type 000000 with funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
  - ADDI 001000, ANDI 001100, ORI 001101, LW 100011, SW 101011, BEQ 000100, HALT 111111.
- FETCH: instr_ready=1. On instr_valid, latch opcode=[31:26] and funct=[5:0], pulse pc_en, go to DECODE. Otherwise hold.
- DECODE: one cycle, register read phase.
  - HALT: set halted, go to HALT.
  - Unknown opcode, or unknown funct with opcode 000000: set illegal, return to FETCH (instruction acts as a NOP).
  - Otherwise go to EXEC.
- EXEC: one cycle; sign/alu_src/alu_con/choose_reg driven per opcode.
  - R-type: alu_src=0, choose_reg=1.
  - ADDI/LW/SW: sign=00, alu_src=1, ADD, choose_reg=0.
  - ANDI/ORI: sign=01, alu_src=1.
  - BEQ: SUB; pulse pc_branch if zero=1, then go to FETCH.
  - LW/SW go to MEM; all others go to WB.
- MEM:
  - mem_req=1, mem_we=(opcode==SW); controls held stable.
  - On mem_ack: SW returns to FETCH, LW goes to WB.
  - If MEM_TIMEOUT cycles pass with no ack: drop mem_req, set illegal, return to FETCH with no register write.
  - mem_ack outside MEM is ignored.
- WB: reg_write=1 for exactly one cycle with EXEC's controls held, then FETCH.
- HALT: terminal. All strobes 0, instr_ready=0; only reset exits.
- Control outputs are registered from state plus latched IR.
- Latency in cycles, fetch handshake to next instr_ready: R/I-type 4; BEQ 3; SW 3+N; LW 4+N (N = mem wait cycles, ≥1).

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined: adds output retired[31:0], reset to 0, incremented on each instruction completion (WB exit, BEQ exit, SW ack).
  - Wraps 0xFFFFFFFF→0.
  - Illegal, timed-out or HALT instructions are not counted.
- Undefined: no counter, no port; all other behaviour identical.

Test Plan:
- Reset release, then ADD (0x00432020) with instr_valid=1:
  - pc_en pulses in cycle 1.
  - EXEC shows alu_con=0010, alu_src=0, choose_reg=1.
  - reg_write=1 in cycle 4 only; instr_ready returns in cycle 5.
- ORI 0x34A5FFFF: sign=01, alu_src=1, alu_con=0001, choose_reg=0, reg_write pulse once.
- BEQ:
  - zero=1 → single pc_branch pulse in EXEC, reg_write never high.
  - zero=0 → no pc_branch.
- LW with mem_ack after 3 cycles:
  - mem_req high for 3 cycles, mem_we=0, then reg_write pulse, total 7 cycles.
  - Repeat as SW: mem_we=1, no reg_write.
- Timeout and illegal:
  - LW with no mem_ack → mem_req drops after 15 cycles, illegal=1, FETCH, no reg_write.
  - Opcode 0x3E → illegal=1, next instruction still executes.
- HALT 0xFC000000: halted=1, instr_ready stays 0 for 20 cycles.
- Reset mid-instruction: assert reset in WB → all outputs 0 asynchronously, no reg_write edge.
- With SEQ_PERF_CNT_EN defined: retired=3 after ADD, BEQ, SW.
